// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the IF/MEM memory bus arbiter: FSM states, bus owner codes
// and a small helper used by the top level.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUS  = 2'd1,
        ST_MEM_BUS = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    function automatic logic bus_busy(input arb_state_t s);
        return (s == ST_IF_BUS) || (s == ST_MEM_BUS);
    endfunction

endpackage

// File: rtl/mem_bus_resp_buf.sv
// One-entry response buffer: holds a completed bus result until the owning
// stage advances (stall low) or an exception flush discards it.
module mem_bus_resp_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              stall,
    input  logic              flush,
    output logic              vld,
    output logic [DATA_W-1:0] data
);

    // A fill never coincides with flush or consume for the same buffer: the
    // arbiter only issues for an empty buffer and drops results under flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld  <= 1'b0;
            data <= '0;
        end else if (fill) begin
            vld  <= 1'b1;
            data <= fill_data;
        end else if (flush || (vld && !stall)) begin
            vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one Wishbone-style bus between instruction fetch and data access,
// MEM first, with a bus watchdog and per-requester response buffers.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_ack,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [DATA_W/8-1:0]   mem_sel,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W-1:0]     mem_rdata,
    output logic                  mem_ack,
    input  logic                  if_stall,
    input  logic                  mem_stall,
    input  logic                  flush,
    output logic                  stallreq_from_if,
    output logic                  stallreq_from_mem,
    output logic                  bus_cyc,
    output logic                  bus_stb,
    output logic                  bus_we,
    output logic [DATA_W/8-1:0]   bus_sel,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic [DATA_W-1:0]     bus_rdata,
    input  logic                  bus_ack,
    output logic                  timeout
);

    localparam int WDOG_W = $clog2(TIMEOUT + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    arb_state_t        state, state_nxt;
    owner_t            owner;
    logic [WDOG_W-1:0] wdog;
    logic              discard_q;
    logic              owner_req, discard_now;
    logic              issue_mem, issue_if, bus_done, bus_to, end_cycle;
    logic              fill_if, fill_mem;
    logic [DATA_W-1:0] fill_data;

    assign stallreq_from_if  = if_req  & ~if_ack  & ~flush;
    assign stallreq_from_mem = mem_req & ~mem_ack & ~flush;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue_mem = 1'b0;
        issue_if  = 1'b0;
        bus_done  = 1'b0;
        bus_to    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_req && !mem_ack) begin
                    state_nxt = ST_MEM_BUS;
                    issue_mem = 1'b1;
                end else if (if_req && !if_ack) begin
                    state_nxt = ST_IF_BUS;
                    issue_if  = 1'b1;
                end
            end
            ST_IF_BUS, ST_MEM_BUS: begin
                if (bus_ack) begin
                    state_nxt = ST_IDLE;
                    bus_done  = 1'b1;
                end else if (wdog == WDOG_LAST) begin
                    state_nxt = ST_IDLE;
                    bus_to    = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A result is dropped if the owner was flushed or withdrew its request at
    // any point during the cycle, including the completing cycle itself.
    assign owner_req   = (owner == OWN_MEM) ? mem_req : if_req;
    assign discard_now = discard_q | flush | ~owner_req;
    assign end_cycle   = bus_done | bus_to;
    assign fill_if     = end_cycle & ~discard_now & (owner == OWN_IF);
    assign fill_mem    = end_cycle & ~discard_now & (owner == OWN_MEM);
    assign fill_data   = (bus_to || bus_we) ? '0 : bus_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_cyc   <= 1'b0;
            bus_stb   <= 1'b0;
            bus_we    <= 1'b0;
            bus_sel   <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            owner     <= OWN_IF;
            wdog      <= '0;
            discard_q <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= bus_to;
            if (issue_mem || issue_if) begin
                bus_cyc   <= 1'b1;
                bus_stb   <= 1'b1;
                owner     <= issue_mem ? OWN_MEM : OWN_IF;
                bus_we    <= issue_mem & mem_we;
                bus_sel   <= issue_mem ? mem_sel : '1;
                bus_addr  <= issue_mem ? mem_addr : if_addr;
                bus_wdata <= issue_mem ? mem_wdata : '0;
                wdog      <= '0;
                discard_q <= 1'b0;
            end else if (end_cycle) begin
                bus_cyc   <= 1'b0;
                bus_stb   <= 1'b0;
                wdog      <= '0;
                discard_q <= 1'b0;
            end else if (bus_busy(state)) begin
                wdog <= wdog + 1'b1;
                if (flush || !owner_req) discard_q <= 1'b1;
            end
        end
    end

    mem_bus_resp_buf #(.DATA_W(DATA_W)) u_if_buf (
        .clk       (clk),
        .rst       (rst),
        .fill      (fill_if),
        .fill_data (fill_data),
        .stall     (if_stall),
        .flush     (flush),
        .vld       (if_ack),
        .data      (if_rdata)
    );

    mem_bus_resp_buf #(.DATA_W(DATA_W)) u_mem_buf (
        .clk       (clk),
        .rst       (rst),
        .fill      (fill_mem),
        .fill_data (fill_data),
        .stall     (mem_stall),
        .flush     (flush),
        .vld       (mem_ack),
        .data      (mem_rdata)
    );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: bench-side requesters and bus slave,
// checked every cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int SEL_W   = DATA_W / 8;
    localparam int TIMEOUT = 16;
    localparam int NCYC    = 2500;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req, mem_req, mem_we, if_stall, mem_stall, flush, bus_ack;
    logic [ADDR_W-1:0] if_addr, mem_addr, bus_addr;
    logic [DATA_W-1:0] if_rdata, mem_rdata, mem_wdata, bus_wdata, bus_rdata;
    logic [SEL_W-1:0]  mem_sel, bus_sel;
    logic              if_ack, mem_ack, stallreq_from_if, stallreq_from_mem;
    logic              bus_cyc, bus_stb, bus_we, timeout;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .if_stall(if_stall), .mem_stall(mem_stall), .flush(flush),
        .stallreq_from_if(stallreq_from_if), .stallreq_from_mem(stallreq_from_mem),
        .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we), .bus_sel(bus_sel),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack), .timeout(timeout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: one outstanding transfer (who/age/drop) plus two result slots.
    bit              m_cyc, m_who, m_drop, m_to, m_fresh;
    int              m_n;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_we;
    logic [SEL_W-1:0]  m_sel;
    bit              m_vld [2];
    logic [DATA_W-1:0] m_dat [2];
    int              s_lat;
    bit              pv_cons [2];
    bit              pv_flush, pv_rst;
    int              mem_hold;

    task automatic model_reset();
        m_cyc = 0; m_who = 0; m_drop = 0; m_to = 0; m_n = 0;
        m_addr = '0; m_wdata = '0; m_we = 0; m_sel = '0;
        m_vld[0] = 0; m_vld[1] = 0; m_dat[0] = '0; m_dat[1] = '0;
        m_fresh = 1;
    endtask

    task automatic start_xfer(input bit w);
        m_cyc  = 1; m_who = w; m_n = 0; m_drop = 0;
        m_addr = w ? mem_addr : if_addr;
        m_we   = w ? mem_we : 1'b0;
        m_sel  = w ? mem_sel : {SEL_W{1'b1}};
        m_wdata = w ? mem_wdata : '0;
        s_lat  = ($urandom_range(0, 19) == 0) ? 1000 : int'($urandom_range(0, 3));
    endtask

    task automatic model_step();
        bit old_vld [2];
        bit req [2];
        bit stl [2];
        bit drop;
        req[0] = if_req;   req[1] = mem_req;
        stl[0] = if_stall; stl[1] = mem_stall;
        pv_cons[0] = 0; pv_cons[1] = 0;
        pv_flush = flush; pv_rst = rst;
        m_to = 0; m_fresh = 0;
        if (rst) begin
            model_reset();
            return;
        end
        old_vld[0] = m_vld[0]; old_vld[1] = m_vld[1];
        for (int r = 0; r < 2; r++) begin
            if (flush) m_vld[r] = 0;
            else if (m_vld[r] && !stl[r]) begin
                m_vld[r] = 0;
                pv_cons[r] = 1;
            end
        end
        if (m_cyc) begin
            drop = m_drop || flush || !req[m_who];
            if (bus_ack || m_n == TIMEOUT - 1) begin
                if (!drop) begin
                    m_vld[m_who] = 1;
                    m_dat[m_who] = (bus_ack && !m_we) ? bus_rdata : '0;
                end
                m_to  = !bus_ack;
                m_cyc = 0;
            end else begin
                m_n++;
                m_drop = drop;
            end
        end else if (mem_req && !old_vld[1]) begin
            start_xfer(1'b1);
        end else if (if_req && !old_vld[0]) begin
            start_xfer(1'b0);
        end
    endtask

    task automatic check_regs();
        check("bus_cyc", bus_cyc, m_cyc);
        check("bus_stb", bus_stb, m_cyc);
        check("timeout", timeout, m_to);
        check("if_ack", if_ack, m_vld[0]);
        check("mem_ack", mem_ack, m_vld[1]);
        if (m_vld[0]) check("if_rdata", if_rdata, m_dat[0]);
        if (m_vld[1]) check("mem_rdata", mem_rdata, m_dat[1]);
        if (m_cyc) begin
            check("bus_addr", bus_addr, m_addr);
            check("bus_we", bus_we, m_we);
            check("bus_sel", bus_sel, m_sel);
            if (m_we) check("bus_wdata", bus_wdata, m_wdata);
        end
        if (m_fresh) begin
            check("rst_bus_addr", bus_addr, 0);
            check("rst_bus_we", bus_we, 0);
            check("rst_bus_sel", bus_sel, 0);
            check("rst_bus_wdata", bus_wdata, 0);
            check("rst_if_rdata", if_rdata, 0);
            check("rst_mem_rdata", mem_rdata, 0);
        end
    endtask

    task automatic drive_inputs(input int cyc);
        rst   = (cyc < 2) || ($urandom_range(0, 299) == 0);
        flush = !rst && ($urandom_range(0, 39) == 0);
        if_stall = ($urandom_range(0, 2) == 0);
        if (mem_hold > 0) begin
            mem_stall = 1'b1;
            mem_hold--;
        end else begin
            mem_stall = ($urandom_range(0, 3) == 0);
            if (m_vld[1] && $urandom_range(0, 5) == 0) begin
                mem_stall = 1'b1;
                mem_hold  = 4;
            end
        end
        if (rst || pv_rst || pv_flush || pv_cons[0]) if_req = 1'b0;
        if (rst || pv_rst || pv_flush || pv_cons[1]) mem_req = 1'b0;
        if (!rst) begin
            if (!if_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    if_req  = 1'b1;
                    if_addr = $urandom & 32'hFFFF_FFFC;
                end
            end else if (!m_vld[0] && $urandom_range(0, 49) == 0) begin
                if_req = 1'b0;
            end
            if (!mem_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    mem_req   = 1'b1;
                    mem_we    = $urandom_range(0, 1) == 1;
                    mem_sel   = SEL_W'($urandom_range(1, 15));
                    mem_addr  = $urandom;
                    mem_wdata = $urandom;
                end
            end else if (!m_vld[1] && $urandom_range(0, 49) == 0) begin
                mem_req = 1'b0;
            end
        end
        bus_rdata = $urandom;
        bus_ack   = m_cyc && (m_n == s_lat);
    endtask

    initial begin
        rst = 1'b1; flush = 0; if_req = 0; mem_req = 0; mem_we = 0;
        if_stall = 0; mem_stall = 0; bus_ack = 0; bus_rdata = '0;
        if_addr = '0; mem_addr = '0; mem_sel = '0; mem_wdata = '0;
        pv_cons[0] = 0; pv_cons[1] = 0; pv_flush = 0; pv_rst = 1;
        mem_hold = 0; s_lat = 0;
        model_reset();
        @(posedge clk);
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            check_regs();
            drive_inputs(cyc);
            #1;
            check("stallreq_if", stallreq_from_if, if_req & ~m_vld[0] & ~flush);
            check("stallreq_mem", stallreq_from_mem, mem_req & ~m_vld[1] & ~flush);
            model_step();
        end
        @(negedge clk);
        check_regs();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
